// File: rtl/reg_operand_fetch.sv
// reg_operand_fetch
//   Register file (NREG x DATA_W) plus operand-fetch stage in front of the
//   16-bit ALU. Decoded instructions arrive over a valid/ready handshake.
//   Both source operands are read, with B optionally replaced by an immediate.
//   The operands, opcode and destination tag are then held in a single-entry
//   output register toward the ALU. ALU results come back on the writeback port.
//
// Ports
//   clk, reset               : single clock, synchronous active-high reset
//   issue_valid/issue_ready  : instruction handshake from the decoder
//   rA, rB, imm_sel, imm     : operand sources (B = imm when imm_sel = 1)
//   op_in, rd_in             : opcode / destination, passed through
//   alu_valid/alu_ready      : operand handshake toward the ALU
//   aIn, bIn, op, rd         : held operand set
//   wb_en, wb_addr, wb_data  : register writeback
//
// Configuration
//   REG_OPERAND_FETCH_FORWARD_EN defined   : writeback data is bypassed into a
//                                            same-cycle read, so the stage never stalls.
//   REG_OPERAND_FETCH_FORWARD_EN undefined : a same-cycle read/write hazard holds
//                                            the issue for one cycle. The issue then
//                                            reads the updated register.
module reg_operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        op_in,
  input  logic [ADDR_W-1:0] rd_in,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [DATA_W-1:0] aIn,
  output logic [DATA_W-1:0] bIn,
  output logic [1:0]        op,
  output logic [ADDR_W-1:0] rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] regFile [NREG];
  logic [DATA_W-1:0] readA;
  logic [DATA_W-1:0] readB;
  logic              stall;
  logic              fire;
  logic              hitA;
  logic              hitB;

  // An immediate operand means rB is not really read, so it cannot cause a hazard.
  assign hitA = wb_en && (wb_addr == rA);
  assign hitB = wb_en && !imm_sel && (wb_addr == rB);

`ifdef REG_OPERAND_FETCH_FORWARD_EN
  assign stall = 1'b0;

  always_comb begin
    readA = hitA ? wb_data : regFile[rA];
    readB = imm_sel ? imm : (hitB ? wb_data : regFile[rB]);
  end
`else
  assign stall = issue_valid && (hitA || hitB);

  always_comb begin
    readA = regFile[rA];
    readB = imm_sel ? imm : regFile[rB];
  end
`endif

  assign issue_ready = (!alu_valid || alu_ready) && !stall;
  assign fire        = issue_valid && issue_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      regFile   <= '{default: '0};
      alu_valid <= 1'b0;
      aIn       <= '0;
      bIn       <= '0;
      op        <= '0;
      rd        <= '0;
    end else begin
      if (wb_en) begin
        regFile[wb_addr] <= wb_data;
      end
      // The held operand set is only reloaded on a fire. A writeback that
      // lands while the stage is stalled therefore cannot disturb it.
      if (fire) begin
        alu_valid <= 1'b1;
        aIn       <= readA;
        bIn       <= readB;
        op        <= op_in;
        rd        <= rd_in;
      end else if (alu_ready) begin
        alu_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_operand_fetch.sv
module tb_reg_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  rA, rB;
  logic        imm_sel;
  logic [15:0] imm;
  logic [1:0]  op_in;
  logic [2:0]  rd_in;
  logic        alu_valid;
  logic        alu_ready;
  logic [15:0] aIn, bIn;
  logic [1:0]  op;
  logic [2:0]  rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  int errors = 0;
  int checks = 0;

  reg_operand_fetch #(.DATA_W(16), .NREG(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rA(rA), .rB(rB), .imm_sel(imm_sel), .imm(imm),
    .op_in(op_in), .rd_in(rd_in),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .aIn(aIn), .bIn(bIn), .op(op), .rd(rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic setIssue(input logic [2:0] a, input logic [2:0] b, input logic isel,
                          input logic [15:0] im, input logic [1:0] o, input logic [2:0] d);
    issue_valid = 1'b1; rA = a; rB = b; imm_sel = isel; imm = im; op_in = o; rd_in = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", alu_valid); end
    checks++; if (aIn !== 16'h0) begin errors++; $display("FAIL reset_aIn got=%0h exp=0", aIn); end
    checks++; if (bIn !== 16'h0) begin errors++; $display("FAIL reset_bIn got=%0h exp=0", bIn); end
    checks++; if (op !== 2'd0 || rd !== 3'd0) begin errors++; $display("FAIL reset_op_rd got=%0h/%0h exp=0/0", op, rd); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0h exp=1", issue_ready); end
    alu_ready = 1'b1;
    setIssue(3'd5, 3'd6, 1'b0, 16'h0, 2'd0, 3'd1);
    tick();
    issue_valid = 1'b0;
    checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL reset_issue_valid got=%0h exp=1", alu_valid); end
    checks++; if (aIn !== 16'h0 || bIn !== 16'h0) begin errors++; $display("FAIL reset_regs_zero got=%0h/%0h exp=0/0", aIn, bIn); end
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL consume_drop got=%0h exp=0", alu_valid); end
  endtask

  task automatic test_basic_fetch();
    writeReg(3'd1, 16'd31);
    writeReg(3'd2, 16'd11);
    setIssue(3'd1, 3'd2, 1'b0, 16'h0, 2'b01, 3'd3);
    tick();
    issue_valid = 1'b0;
    checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0h exp=1", alu_valid); end
    checks++; if (aIn !== 16'd31) begin errors++; $display("FAIL basic_aIn got=%0d exp=31", aIn); end
    checks++; if (bIn !== 16'd11) begin errors++; $display("FAIL basic_bIn got=%0d exp=11", bIn); end
    checks++; if (op !== 2'b01 || rd !== 3'd3) begin errors++; $display("FAIL basic_op_rd got=%0h/%0h exp=1/3", op, rd); end
    tick();
  endtask

  task automatic test_immediate();
    writeReg(3'd4, 16'h001F);
    // A write to rB must not stall while B comes from the immediate.
    setIssue(3'd4, 3'd2, 1'b1, 16'hFFF4, 2'b11, 3'd5);
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0777;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL imm_no_stall got=%0h exp=1", issue_ready); end
    tick();
    issue_valid = 1'b0; wb_en = 1'b0;
    checks++; if (aIn !== 16'h001F) begin errors++; $display("FAIL imm_aIn got=%0h exp=1f", aIn); end
    checks++; if (bIn !== 16'hFFF4) begin errors++; $display("FAIL imm_bIn got=%0h exp=fff4", bIn); end
    checks++; if (op !== 2'b11 || alu_valid !== 1'b1) begin errors++; $display("FAIL imm_op got=%0h/%0h exp=3/1", op, alu_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    // R1=31, R2=0x0777
    setIssue(3'd1, 3'd2, 1'b0, 16'h0, 2'b00, 3'd6);
    tick();
    alu_ready = 1'b0;
    setIssue(3'd2, 3'd1, 1'b0, 16'h0, 2'b10, 3'd7);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h1234; end
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%0h exp=0", i, issue_ready); end
      tick();
      wb_en = 1'b0;
      checks++; if (alu_valid !== 1'b1 || aIn !== 16'd31 || bIn !== 16'h0777 || op !== 2'b00 || rd !== 3'd6) begin
        errors++; $display("FAIL bp_frozen[%0d] got=%0h/%0h/%0h/%0h/%0h exp=1/1f/777/0/6", i, alu_valid, aIn, bIn, op, rd);
      end
    end
    alu_ready = 1'b1;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0h exp=1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    checks++; if (alu_valid !== 1'b1 || aIn !== 16'h0777 || bIn !== 16'h1234 || op !== 2'b10 || rd !== 3'd7) begin
      errors++; $display("FAIL bp_reload got=%0h/%0h/%0h/%0h/%0h exp=1/777/1234/2/7", alu_valid, aIn, bIn, op, rd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // R1=0x1234, R2=0x0777, R4=0x001F
    logic [2:0]  ta [3] = '{3'd1, 3'd4, 3'd2};
    logic [2:0]  tb [3] = '{3'd4, 3'd2, 3'd1};
    logic        ts [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] ea [3] = '{16'h1234, 16'h001F, 16'h0777};
    logic [15:0] eb [3] = '{16'h001F, 16'h0777, 16'hABCD};
    alu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setIssue(ta[i], tb[i], ts[i], 16'hABCD, 2'(i), 3'(i));
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%0h exp=1", i, issue_ready); end
      tick();
      checks++; if (alu_valid !== 1'b1 || aIn !== ea[i] || bIn !== eb[i] || op !== 2'(i)) begin
        errors++; $display("FAIL b2b_data[%0d] got=%0h/%0h/%0h/%0h exp=1/%0h/%0h/%0h", i, alu_valid, aIn, bIn, op, ea[i], eb[i], i);
      end
    end
    issue_valid = 1'b0; imm_sel = 1'b0;
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0h exp=0", alu_valid); end
  endtask

  task automatic test_hazard();
    alu_ready = 1'b1;
    setIssue(3'd3, 3'd0, 1'b0, 16'h0, 2'b01, 3'd2);
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h002A;
    #1;
`ifdef REG_OPERAND_FETCH_FORWARD_EN
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL hz_ready got=%0h exp=1", issue_ready); end
    tick();
    wb_en = 1'b0; issue_valid = 1'b0;
`else
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL hz_stall got=%0h exp=0", issue_ready); end
    tick();
    wb_en = 1'b0;
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL hz_no_fire got=%0h exp=0", alu_valid); end
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL hz_ready_next got=%0h exp=1", issue_ready); end
    tick();
    issue_valid = 1'b0;
`endif
    checks++; if (alu_valid !== 1'b1 || aIn !== 16'h002A || rd !== 3'd2) begin
      errors++; $display("FAIL hz_aIn got=%0h/%0h/%0h exp=1/2a/2", alu_valid, aIn, rd);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    alu_ready = 1'b0;
    setIssue(3'd1, 3'd2, 1'b0, 16'h0, 2'b00, 3'd1);
    tick();
    issue_valid = 1'b0;
    checks++; if (alu_valid !== 1'b1 || aIn !== 16'h1234) begin errors++; $display("FAIL mid_held got=%0h/%0h exp=1/1234", alu_valid, aIn); end
    reset = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h5555;
    tick();
    reset = 1'b0; wb_en = 1'b0;
    checks++; if (alu_valid !== 1'b0 || aIn !== 16'h0) begin errors++; $display("FAIL mid_reset got=%0h/%0h exp=0/0", alu_valid, aIn); end
    alu_ready = 1'b1;
    setIssue(3'd1, 3'd5, 1'b0, 16'h0, 2'b00, 3'd0);
    tick();
    issue_valid = 1'b0;
    checks++; if (alu_valid !== 1'b1 || aIn !== 16'h0 || bIn !== 16'h0) begin
      errors++; $display("FAIL mid_regs_cleared got=%0h/%0h/%0h exp=1/0/0", alu_valid, aIn, bIn);
    end
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; rA = '0; rB = '0; imm_sel = 1'b0; imm = '0;
    op_in = '0; rd_in = '0; alu_ready = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    test_reset();
    test_basic_fetch();
    test_immediate();
    test_backpressure();
    test_back_to_back();
    test_hazard();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
